// File: rtl/egg_timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : egg_timer_ctrl_pkg
// Brief    : State encodings, BCD digit limits and default tick divider.
// Revision : 1.0
// ============================================================================
package egg_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0]  SEC_TENS_MAX     = 4'd5;
  localparam logic [3:0]  ONES_MAX         = 4'd9;
  localparam int unsigned TICK_DIV_DEFAULT = 50_000_000;

endpackage
`default_nettype wire

// File: rtl/bcd_mod60.sv
`default_nettype none
// ============================================================================
// Module   : bcd_mod60
// Brief    : Two-digit BCD register counting 00..59 with inc/dec/clr.
// Revision : 1.0
// ============================================================================
module bcd_mod60
  import egg_timer_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       clr_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       zero_o,
  output logic       borrow_out_o
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr_i) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (inc_i) begin
      if (ones_q == ONES_MAX) begin
        ones_d = 4'd0;
        tens_d = (tens_q == SEC_TENS_MAX) ? 4'd0 : tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (dec_i) begin
      // 00 wraps to 59; the caller sees borrow_out_o in the same cycle
      if (ones_q == 4'd0) begin
        ones_d = ONES_MAX;
        tens_d = (tens_q == 4'd0) ? SEC_TENS_MAX : tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens_o       = tens_q;
  assign ones_o       = ones_q;
  assign zero_o       = (tens_q == 4'd0) && (ones_q == 4'd0);
  assign borrow_out_o = dec_i && !clr_i && !inc_i && zero_o;

endmodule
`default_nettype wire

// File: rtl/egg_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : egg_timer_ctrl
// Brief    : MM:SS egg-timer countdown with BCD digits and blinking finish.
// Revision : 1.0
// ============================================================================
module egg_timer_ctrl
  import egg_timer_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_set_min,
  input  logic       btn_set_sec,
  input  logic       btn_start,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       blank
);

  localparam int unsigned    PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_e             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               blank_q, blank_d;

  logic w_tick;
  logic w_sec_zero, w_min_zero, w_time_zero, w_last_sec;
  logic w_sec_inc, w_min_inc, w_sec_dec, w_min_dec, w_clr;
  logic w_unused_min_borrow;

  assign w_tick      = (pre_q == PRE_LAST);
  assign w_time_zero = w_sec_zero && w_min_zero;
  assign w_last_sec  = w_min_zero && (sec_tens == 4'd0) && (sec_ones == 4'd1);

  assign w_sec_inc = (state_q == ST_SET) && btn_set_sec;
  assign w_min_inc = (state_q == ST_SET) && btn_set_min;
  assign w_sec_dec = (state_q == ST_RUN) && w_tick && !btn_start;
  assign w_clr     = (state_q == ST_DONE) && btn_start;

  bcd_mod60 u_sec (
    .clk          (clk),
    .reset        (reset),
    .inc_i        (w_sec_inc),
    .dec_i        (w_sec_dec),
    .clr_i        (w_clr),
    .tens_o       (sec_tens),
    .ones_o       (sec_ones),
    .zero_o       (w_sec_zero),
    .borrow_out_o (w_min_dec)
  );

  bcd_mod60 u_min (
    .clk          (clk),
    .reset        (reset),
    .inc_i        (w_min_inc),
    .dec_i        (w_min_dec),
    .clr_i        (w_clr),
    .tens_o       (min_tens),
    .ones_o       (min_ones),
    .zero_o       (w_min_zero),
    .borrow_out_o (w_unused_min_borrow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SET;
      pre_q   <= '0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      blank_q <= blank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SET:   if (btn_start && !w_time_zero) state_d = ST_RUN;
      ST_RUN: begin
        // a pause wins over a coincident tick, dropping that decrement
        if (btn_start)                 state_d = ST_PAUSE;
        else if (w_tick && w_last_sec) state_d = ST_DONE;
      end
      ST_PAUSE: if (btn_start) state_d = ST_RUN;
      ST_DONE:  if (btn_start) state_d = ST_SET;
      default:  state_d = ST_SET;
    endcase
  end

  always_comb begin
    pre_d   = pre_q;
    blank_d = 1'b0;
    case (state_q)
      ST_SET:   pre_d = '0;
      ST_RUN:   pre_d = w_tick ? '0 : pre_q + 1'b1;
      ST_PAUSE: pre_d = pre_q;
      ST_DONE: begin
        if (btn_start) begin
          pre_d   = '0;
          blank_d = 1'b0;
        end else begin
          pre_d   = w_tick ? '0 : pre_q + 1'b1;
          blank_d = w_tick ? !blank_q : blank_q;
        end
      end
      default:  pre_d = '0;
    endcase
  end

  always_comb begin
    running = (state_q == ST_RUN);
    done    = (state_q == ST_DONE);
  end

  assign blank = blank_q;

endmodule
`default_nettype wire

// File: tb/tb_egg_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_egg_timer_ctrl
// Brief    : Directed plus random bench for egg_timer_ctrl against a seconds-level model.
// Revision : 1.0
// ============================================================================
module tb_egg_timer_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_set_min = 1'b0;
  logic       btn_set_sec = 1'b0;
  logic       btn_start = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, done, blank;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: mode 0=set 1=run 2=pause 3=done, time kept as plain minutes/seconds
  int m_mode, m_min, m_sec, m_phase;
  bit m_blank;

  egg_timer_ctrl #(.TICK_DIV(TD)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_set_min (btn_set_min),
    .btn_set_sec (btn_set_sec),
    .btn_start   (btn_start),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .running     (running),
    .done        (done),
    .blank       (blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dut_time();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  function automatic logic [15:0] bcd_time(input int mm, input int ss);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_step(input bit st, input bit mi, input bit se, input bit rs);
    bit tick;
    int t;
    if (rs) begin
      m_mode = 0; m_min = 0; m_sec = 0; m_phase = 0; m_blank = 0;
      return;
    end
    tick = (m_phase == TD - 1);
    case (m_mode)
      0: begin
        if (st && (m_min != 0 || m_sec != 0)) begin
          m_mode  = 1;
          m_phase = 0;
        end
        if (mi) m_min = (m_min + 1) % 60;
        if (se) m_sec = (m_sec + 1) % 60;
      end
      1: begin
        m_phase = (m_phase + 1) % TD;
        if (st) m_mode = 2;
        else if (tick) begin
          t     = m_min * 60 + m_sec - 1;
          m_min = t / 60;
          m_sec = t % 60;
          if (t == 0) m_mode = 3;
        end
      end
      2: if (st) m_mode = 1;
      default: begin
        if (st) begin
          m_mode = 0; m_min = 0; m_sec = 0; m_phase = 0; m_blank = 0;
        end else begin
          m_phase = (m_phase + 1) % TD;
          if (tick) m_blank = !m_blank;
        end
      end
    endcase
  endtask

  task automatic cyc(input bit st, input bit mi, input bit se, input bit rs);
    @(negedge clk);
    btn_start   = st;
    btn_set_min = mi;
    btn_set_sec = se;
    reset       = rs;
    @(posedge clk);
    model_step(st, mi, se, rs);
    #1;
    chk("time",    dut_time(), bcd_time(m_min, m_sec));
    chk("running", 16'(running), 16'(m_mode == 1));
    chk("done",    16'(done),    16'(m_mode == 3));
    chk("blank",   16'(blank),   16'(m_blank));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    m_mode = 0; m_min = 0; m_sec = 0; m_phase = 0; m_blank = 0;

    // reset state and reset mid-count
    cyc(0, 0, 0, 1);
    chk("reset_time", dut_time(), 16'h0000);
    chk("reset_flags", 16'({running, done, blank}), 16'h0000);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 1, 0);
    chk("preset_0130", dut_time(), 16'h0130);
    cyc(1, 0, 0, 0);
    chk("run_started", 16'(running), 16'h0001);
    idle(5);
    cyc(0, 0, 0, 1);
    chk("midcount_reset_time", dut_time(), 16'h0000);
    chk("midcount_reset_run", 16'(running), 16'h0000);

    // set wrap and simultaneous presses
    for (int i = 0; i < 61; i++) cyc(0, 0, 1, 0);
    chk("sec_wrap", dut_time(), 16'h0001);
    for (int i = 0; i < 60; i++) cyc(0, 1, 0, 0);
    chk("min_wrap", dut_time(), 16'h0001);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 1, 0);
    chk("both_set", dut_time(), 16'h0101);

    // borrow chain 10:00 -> 09:59 -> 09:58
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    idle(3);
    chk("before_first_tick", dut_time(), 16'h1000);
    idle(1);
    chk("borrow_0959", dut_time(), 16'h0959);
    idle(4);
    chk("next_0958", dut_time(), 16'h0958);

    // zero start ignored; pause and resume
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    chk("zero_start_ignored", 16'(running), 16'h0000);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    idle(4);
    chk("one_tick_0002", dut_time(), 16'h0002);
    cyc(1, 0, 0, 0);
    idle(20);
    chk("paused_hold", dut_time(), 16'h0002);
    cyc(1, 0, 0, 0);
    idle(3);
    chk("resume_0001", dut_time(), 16'h0001);
    idle(4);
    chk("reach_done", 16'(done), 16'h0001);

    // completion and blink
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    idle(4);
    chk("done_flag", 16'({running, done, blank}), 16'h0002);
    chk("done_time", dut_time(), 16'h0000);
    idle(4);
    chk("blink_1", 16'(blank), 16'h0001);
    idle(4);
    chk("blink_0", 16'(blank), 16'h0000);
    idle(4);
    chk("blink_1b", 16'(blank), 16'h0001);
    cyc(1, 0, 0, 0);
    chk("ack_flags", 16'({running, done, blank}), 16'h0000);

    // start colliding with a tick, then set presses while running
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    idle(3);
    cyc(1, 0, 0, 0);
    chk("collision_hold", dut_time(), 16'h0005);
    chk("collision_paused", 16'(running), 16'h0000);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    chk("set_ignored_in_run", dut_time(), 16'h0005);

    // random stimulus against the model
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      bit st, mi, se, rs;
      st = ($urandom_range(0, 99) < 3);
      mi = ($urandom_range(0, 199) < 1);
      se = ($urandom_range(0, 99) < 8);
      rs = ($urandom_range(0, 999) < 2);
      cyc(st, mi, se, rs);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
